// File: rtl/eq_ctrl_pkg.sv
// Shared types and constants for the equalizer menu controller.
package eq_ctrl_pkg;

   localparam int NUM_BANDS = 8;
   localparam int GAIN_W    = 4;
   localparam int BAND_W    = 3;
   localparam int OFFSET_W  = 3;

   localparam logic [GAIN_W-1:0]   GAIN_MAX     = 4'd15;
   localparam logic [GAIN_W-1:0]   GAIN_DEFAULT = 4'd8;
   localparam logic [OFFSET_W-1:0] OFFSET_MAX   = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_PLAY        = 3'd1,
      ST_MENU        = 3'd2,
      ST_EDIT_BAND   = 3'd3,
      ST_EDIT_GAIN   = 3'd4,
      ST_EDIT_OFFSET = 3'd5
   } ui_state_e;

   typedef enum logic [2:0] {
      MENU_BAND_EQ   = 3'd0,
      MENU_OFFSET    = 3'd1,
      MENU_RESET_ALL = 3'd2
   } menu_item_e;

endpackage

// File: rtl/eq_menu_ctrl_cfg_update_queue.sv
// Pending-band mask and the valid/ready output register that streams changed gains,
// lowest band index first.
module cfg_update_queue
   import eq_ctrl_pkg::*;
(
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NUM_BANDS-1:0]          i_set_mask,
   input  logic                          i_set_all,
   input  logic [NUM_BANDS*GAIN_W-1:0]   i_gains,
   input  logic                          i_ready,
   output logic                          o_valid,
   output logic [BAND_W-1:0]             o_band,
   output logic [GAIN_W-1:0]             o_gain
);

   logic [NUM_BANDS-1:0] pend_q, pend_d, clr;
   logic                 valid_q, valid_d;
   logic [BAND_W-1:0]    band_q, band_d;
   logic [GAIN_W-1:0]    gain_q, gain_d;
   logic                 found;
   logic [BAND_W-1:0]    idx;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = NUM_BANDS-1; i >= 0; i--) begin
         if (pend_q[i]) begin
            found = 1'b1;
            idx   = BAND_W'(i);
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      band_d  = band_q;
      gain_d  = gain_q;
      clr     = '0;
      if (!valid_q || i_ready) begin
         if (found) begin
            valid_d  = 1'b1;
            band_d   = idx;
            gain_d   = i_gains[int'(idx)*GAIN_W +: GAIN_W];
            clr[idx] = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end
      // Sets are OR-ed in after the clear so a fresh edit re-queues the band.
      pend_d = (pend_q & ~clr) | i_set_mask | {NUM_BANDS{i_set_all}};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pend_q  <= '1;
         valid_q <= 1'b0;
         band_q  <= '0;
         gain_q  <= '0;
      end else begin
         pend_q  <= pend_d;
         valid_q <= valid_d;
         band_q  <= band_d;
         gain_q  <= gain_d;
      end
   end

   assign o_valid = valid_q;
   assign o_band  = band_q;
   assign o_gain  = gain_q;

endmodule

// File: rtl/eq_menu_ctrl.sv
// Equalizer UI controller: key-driven menu FSM, per-band gain and offset registers,
// and the config stream of changed gains to the EQ coefficient block.
//
//   state          | meaning
//   ST_IDLE        | playback off, follows i_switch
//   ST_PLAY        | playback on, follows i_switch
//   ST_MENU        | cursor over band EQ / offset / reset all
//   ST_EDIT_BAND   | choosing a band
//   ST_EDIT_GAIN   | adjusting gain of the chosen band
//   ST_EDIT_OFFSET | adjusting output offset
module eq_menu_ctrl
   import eq_ctrl_pkg::*;
(
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_select,
   input  logic                        i_back,
   input  logic                        i_up,
   input  logic                        i_down,
   input  logic                        i_switch,
   output logic [2:0]                  o_state,
   output logic [2:0]                  o_menu_state,
   output logic [BAND_W-1:0]           o_band,
   output logic [NUM_BANDS*GAIN_W-1:0] o_gain,
   output logic [OFFSET_W-1:0]         o_offset,
   output logic                        o_cfg_valid,
   output logic [BAND_W-1:0]           o_cfg_band,
   output logic [GAIN_W-1:0]           o_cfg_gain,
   input  logic                        i_cfg_ready
);

   ui_state_e                   state_q, state_d;
   menu_item_e                  menu_q, menu_d;
   logic [BAND_W-1:0]           band_q, band_d;
   logic [NUM_BANDS*GAIN_W-1:0] gains_q, gains_d;
   logic [OFFSET_W-1:0]         offset_q, offset_d;
   logic [NUM_BANDS-1:0]        set_mask;
   logic                        set_all;
   logic                        k_back, k_sel, k_up, k_down;
   logic [GAIN_W-1:0]           cur_gain;
   ui_state_e                   run_state;

   // One key per cycle: back > select > up > down.
   assign k_back = i_back;
   assign k_sel  = i_select & ~i_back;
   assign k_up   = i_up & ~i_back & ~i_select;
   assign k_down = i_down & ~i_back & ~i_select & ~i_up;

   assign cur_gain  = gains_q[int'(band_q)*GAIN_W +: GAIN_W];
   assign run_state = i_switch ? ST_PLAY : ST_IDLE;

   always_comb begin
      state_d  = state_q;
      menu_d   = menu_q;
      band_d   = band_q;
      gains_d  = gains_q;
      offset_d = offset_q;
      set_mask = '0;
      set_all  = 1'b0;
      case (state_q)
         ST_IDLE, ST_PLAY: begin
            if (k_sel) begin
               state_d = ST_MENU;
               menu_d  = MENU_BAND_EQ;
            end else begin
               state_d = run_state;
            end
         end
         ST_MENU: begin
            if (k_back) begin
               state_d = run_state;
            end else if (k_sel) begin
               case (menu_q)
                  MENU_BAND_EQ: state_d = ST_EDIT_BAND;
                  MENU_OFFSET:  state_d = ST_EDIT_OFFSET;
                  default: begin
                     gains_d  = {NUM_BANDS{GAIN_DEFAULT}};
                     offset_d = '0;
                     set_all  = 1'b1;
                  end
               endcase
            end else if (k_up) begin
               menu_d = (menu_q == MENU_RESET_ALL) ? MENU_BAND_EQ : menu_item_e'(menu_q + 3'd1);
            end else if (k_down) begin
               menu_d = (menu_q == MENU_BAND_EQ) ? MENU_RESET_ALL : menu_item_e'(menu_q - 3'd1);
            end
         end
         ST_EDIT_BAND: begin
            if (k_back)      state_d = ST_MENU;
            else if (k_sel)  state_d = ST_EDIT_GAIN;
            else if (k_up)   band_d  = band_q + 1'b1;
            else if (k_down) band_d  = band_q - 1'b1;
         end
         ST_EDIT_GAIN: begin
            if (k_back || k_sel) begin
               state_d = ST_EDIT_BAND;
            end else if (k_up && cur_gain != GAIN_MAX) begin
               gains_d[int'(band_q)*GAIN_W +: GAIN_W] = cur_gain + 1'b1;
               set_mask[band_q] = 1'b1;
            end else if (k_down && cur_gain != '0) begin
               gains_d[int'(band_q)*GAIN_W +: GAIN_W] = cur_gain - 1'b1;
               set_mask[band_q] = 1'b1;
            end
         end
         ST_EDIT_OFFSET: begin
            if (k_back || k_sel)                     state_d  = ST_MENU;
            else if (k_up && offset_q != OFFSET_MAX) offset_d = offset_q + 1'b1;
            else if (k_down && offset_q != '0)       offset_d = offset_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         menu_q   <= MENU_BAND_EQ;
         band_q   <= '0;
         gains_q  <= {NUM_BANDS{GAIN_DEFAULT}};
         offset_q <= '0;
      end else begin
         state_q  <= state_d;
         menu_q   <= menu_d;
         band_q   <= band_d;
         gains_q  <= gains_d;
         offset_q <= offset_d;
      end
   end

   cfg_update_queue u_cfg_queue (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_set_mask (set_mask),
      .i_set_all  (set_all),
      .i_gains    (gains_q),
      .i_ready    (i_cfg_ready),
      .o_valid    (o_cfg_valid),
      .o_band     (o_cfg_band),
      .o_gain     (o_cfg_gain)
   );

   assign o_state      = state_q;
   assign o_menu_state = menu_q;
   assign o_band       = band_q;
   assign o_gain       = gains_q;
   assign o_offset     = offset_q;

endmodule

// File: tb/tb_eq_menu_ctrl.sv
// Directed bench for eq_menu_ctrl: a table of single-cycle key vectors plus hand-written
// sequences for saturation, back-pressure, reset-all and reset during a config stream.
module tb_eq_menu_ctrl;
   import eq_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst, sel, back, up, down, sw, ready;
   logic [2:0]  st, menu, band, off, cb;
   logic [31:0] gain;
   logic        cv;
   logic [3:0]  cg;

   always #5 clk = ~clk;

   eq_menu_ctrl dut (
      .i_clk(clk), .i_rst(rst), .i_select(sel), .i_back(back), .i_up(up), .i_down(down),
      .i_switch(sw), .o_state(st), .o_menu_state(menu), .o_band(band), .o_gain(gain),
      .o_offset(off), .o_cfg_valid(cv), .o_cfg_band(cb), .o_cfg_gain(cg), .i_cfg_ready(ready)
   );

   typedef struct {
      logic [3:0] keys;   // {back, select, up, down}
      logic       sw;
      logic [2:0] st;
      logic [2:0] menu;
      logic [2:0] band;
      logic [3:0] g;
      logic [2:0] off;
   } vec_t;

   vec_t       vecs[$];
   logic [6:0] words[$];
   int         num_checks = 0;
   int         num_errors = 0;

   always @(posedge clk) if (!rst && cv && ready) words.push_back({cb, cg});

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      num_checks++;
      if (act !== exp) begin
         num_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic v(input logic [3:0] k, input logic s, input logic [2:0] e_st, input logic [2:0] e_menu,
                    input logic [2:0] e_band, input logic [3:0] e_g, input logic [2:0] e_off);
      vec_t e;
      e.keys = k; e.sw = s; e.st = e_st; e.menu = e_menu; e.band = e_band; e.g = e_g; e.off = e_off;
      vecs.push_back(e);
   endtask

   task automatic press(input logic [3:0] k);
      {back, sel, up, down} = k;
      @(negedge clk);
      {back, sel, up, down} = 4'b0000;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [3:0] gain_of(input logic [2:0] b);
      return gain[int'(b)*4 +: 4];
   endfunction

   task automatic chk_full_push(input string name);
      chk({name, "_count"}, words.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < words.size()) chk($sformatf("%s_w%0d", name, i), words[i], {3'(i), 4'd8});
   endtask

   initial begin
      rst = 1'b1; {back, sel, up, down} = 4'b0000; sw = 1'b0; ready = 1'b1;

      // keys: back sel up down | sw | state menu band gain[band] offset
      v(4'b0000, 1, 1, 0, 0, 8, 0);
      v(4'b0000, 0, 0, 0, 0, 8, 0);
      v(4'b0100, 1, 2, 0, 0, 8, 0);
      v(4'b0001, 1, 2, 2, 0, 8, 0);
      v(4'b0010, 1, 2, 0, 0, 8, 0);
      v(4'b0010, 1, 2, 1, 0, 8, 0);
      v(4'b0100, 1, 5, 1, 0, 8, 0);
      v(4'b0001, 1, 5, 1, 0, 8, 0);
      for (int i = 1; i <= 7; i++) v(4'b0010, 1, 5, 1, 0, 8, 3'(i));
      v(4'b0010, 1, 5, 1, 0, 8, 7);
      v(4'b0001, 1, 5, 1, 0, 8, 6);
      v(4'b1000, 1, 2, 1, 0, 8, 6);
      v(4'b0010, 1, 2, 2, 0, 8, 6);
      v(4'b0010, 1, 2, 0, 0, 8, 6);
      v(4'b0100, 1, 3, 0, 0, 8, 6);
      v(4'b0001, 1, 3, 0, 7, 8, 6);
      v(4'b0010, 1, 3, 0, 0, 8, 6);
      v(4'b0010, 1, 3, 0, 1, 8, 6);
      v(4'b0010, 1, 3, 0, 2, 8, 6);
      v(4'b0100, 1, 4, 0, 2, 8, 6);
      v(4'b0010, 1, 4, 0, 2, 9, 6);
      v(4'b1000, 1, 3, 0, 2, 9, 6);
      v(4'b1000, 1, 2, 0, 2, 9, 6);
      v(4'b1110, 1, 1, 0, 2, 9, 6);
      v(4'b0111, 1, 2, 0, 2, 9, 6);
      v(4'b0011, 1, 2, 1, 2, 9, 6);
      v(4'b1000, 0, 0, 1, 2, 9, 6);

      // Reset state and the full push that follows it
      idle(2);
      chk("rst_state", st, 0);
      chk("rst_menu", menu, 0);
      chk("rst_band", band, 0);
      chk("rst_gain", gain, 32'h8888_8888);
      chk("rst_offset", off, 0);
      chk("rst_valid", cv, 0);
      chk("rst_cfg", {cb, cg}, 0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("push_w%0d", i), {cv, cb, cg}, {1'b1, 3'(i), 4'd8});
      end
      @(negedge clk);
      chk("push_done_valid", cv, 0);
      words.delete();

      foreach (vecs[i]) begin
         {back, sel, up, down} = vecs[i].keys;
         sw = vecs[i].sw;
         @(negedge clk);
         {back, sel, up, down} = 4'b0000;
         chk($sformatf("v%0d_state", i), st, vecs[i].st);
         chk($sformatf("v%0d_menu", i), menu, vecs[i].menu);
         chk($sformatf("v%0d_band", i), band, vecs[i].band);
         chk($sformatf("v%0d_gain", i), gain_of(band), vecs[i].g);
         chk($sformatf("v%0d_offset", i), off, vecs[i].off);
      end
      idle(2);
      chk("tbl_words", words.size(), 1);
      if (words.size() >= 1) chk("tbl_word0", words[0], {3'd2, 4'd9});

      // Gain saturation at 15: no word for a no-op, word for the step back down
      press(4'b0100); press(4'b0100); press(4'b0100);
      chk("sat_state", st, 4);
      repeat (6) press(4'b0010);
      idle(3);
      chk("sat_gain15", gain_of(2), 15);
      words.delete();
      press(4'b0010); press(4'b0010);
      idle(3);
      chk("sat_hold", gain_of(2), 15);
      chk("sat_nowords", words.size(), 0);
      press(4'b0001);
      idle(3);
      chk("sat_gain14", gain_of(2), 14);
      chk("sat_words", words.size(), 1);
      if (words.size() >= 1) chk("sat_word", words[0], {3'd2, 4'd14});

      // Back-pressure: payload held while the band is edited again, then both values sent
      ready = 1'b0;
      words.delete();
      press(4'b0001); press(4'b0001);
      idle(3);
      chk("bp_held", {cv, cb, cg}, {1'b1, 3'd2, 4'd13});
      chk("bp_gain", gain_of(2), 12);
      ready = 1'b1;
      idle(4);
      chk("bp_words", words.size(), 2);
      if (words.size() >= 2) begin
         chk("bp_w0", words[0], {3'd2, 4'd13});
         chk("bp_w1", words[1], {3'd2, 4'd12});
      end
      chk("bp_valid_off", cv, 0);

      // Reset-all from the menu
      press(4'b1000); press(4'b1000); press(4'b0001);
      chk("ra_cursor", menu, 2);
      words.delete();
      press(4'b0100);
      chk("ra_state", st, 2);
      chk("ra_gain", gain, 32'h8888_8888);
      chk("ra_offset", off, 0);
      idle(10);
      chk_full_push("ra");

      // Reset in the middle of a full push
      words.delete();
      press(4'b0100);
      idle(2);
      chk("mid_valid_pre", cv, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", cv, 0);
      chk("mid_rst_state", st, 0);
      @(negedge clk);
      words.delete();
      rst = 1'b0;
      idle(10);
      chk_full_push("mid");
      chk("mid_state_idle", st, 0);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
